// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Word-addressed data memory slave with a fixed, parameterised
//                response latency, byte-enable writes and error reporting for
//                misaligned or out-of-range accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         c_idx_w    = $clog2(DEPTH);
  localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [3:0]  r_cnt;

  // Request fields captured on the accept edge
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;

  // Response registers
  logic        r_err;
  logic [31:0] r_rdata;

  // Storage array; intentionally not reset
  logic [31:0] mem [DEPTH];

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_acc_we;
  logic [31:0]        w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic [3:0]         w_acc_be;
  logic               w_acc_bad;
  logic [c_idx_w-1:0] w_acc_idx;

  assign w_accept     = (r_state == c_st_idle) && req;
  assign w_enter_resp = (r_state != c_st_resp) && (w_next == c_st_resp);

  // With a single-cycle latency the array is accessed on the same edge that
  // accepts the request, so the live inputs must feed the access path; for
  // longer latencies the captured copy is used so later input changes are
  // invisible to the in-flight transaction.
  generate
    if (LATENCY == 1) begin : g_direct_access
      assign w_acc_we    = we;
      assign w_acc_addr  = addr;
      assign w_acc_wdata = wdata;
      assign w_acc_be    = be;
    end else begin : g_captured_access
      assign w_acc_we    = r_we;
      assign w_acc_addr  = r_addr;
      assign w_acc_wdata = r_wdata;
      assign w_acc_be    = r_be;
    end
  endgenerate

  // Misaligned or beyond the array -> error response, no array side effects
  assign w_acc_bad = (w_acc_addr[1:0] != 2'b00) ||
                     ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH));
  assign w_acc_idx = w_acc_addr[c_idx_w+1:2];

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->)* RESP -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (req) begin
          w_next = (LATENCY == 1) ? c_st_resp : c_st_wait;
        end
      end
      c_st_wait: begin
        if (r_cnt <= 4'd1) begin
          w_next = c_st_resp;
        end
      end
      c_st_resp: begin
        w_next = c_st_idle;
      end
      default: begin
        w_next = c_st_idle;
      end
    endcase
  end

  // Output decode: handshake flags follow the state, error only with ack
  always_comb begin
    ready = (r_state == c_st_idle);
    ack   = (r_state == c_st_resp);
    err   = (r_state == c_st_resp) && r_err;
    rdata = r_rdata;
  end

  // Latency counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_cnt_load;
    end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture the request fields on the accept edge
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
    end else if (w_accept) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
      r_be    <= be;
    end
  end

  // Response data and error flag, updated only on the edge entering RESP
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else if (w_enter_resp) begin
      r_err <= w_acc_bad;
      if (w_acc_bad) begin
        r_rdata <= 32'h0;
      end else if (!w_acc_we) begin
        r_rdata <= mem[w_acc_idx];
      end
    end
  end

  // Byte-lane array write on the edge entering RESP; gated by clrn so a
  // request presented while reset is held can never reach the array
  always_ff @(posedge clk) begin
    if (clrn && w_enter_resp && w_acc_we && !w_acc_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) begin
          mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. A transaction
//                level model predicts ready/ack/err/rdata every cycle for the
//                LATENCY=2 instance; directed sequences pin literal results and
//                a LATENCY=1 instance checks the single-cycle path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int LAT = 2;
  localparam int DEP = 64;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ready, ack, err;
  logic [31:0] rdata;

  logic        req1, we1;
  logic [31:0] addr1, wdata1;
  logic [3:0]  be1;
  logic        ready1, ack1, err1;
  logic [31:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEP), .LATENCY(LAT)) u_dut (
    .clk(clk), .clrn(clrn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .ack(ack), .rdata(rdata), .err(err)
  );

  data_mem_responder #(.DEPTH(DEP), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .clrn(clrn), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .be(be1), .ready(ready1), .ack(ack1), .rdata(rdata1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within cycle budget at t=%0t", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level model: edges are numbered from reset release; a request
  // seen at edge e >= m_nxt is accepted, completes at edge e+LAT-1 and the
  // next request can be taken at edge e+LAT+1.
  // --------------------------------------------------------------------------
  int          m_edge, m_nxt, m_resp, m_idx;
  bit          m_pend, m_ack, m_err, m_ready;
  logic [31:0] m_rdata, m_mask;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;
  logic [31:0] mm [DEP];
  logic [3:0]  bv [DEP] = '{default: 4'h0};

  always begin
    @(posedge clk);
    if (!clrn) begin
      m_edge = 0; m_nxt = 0; m_pend = 0; m_ack = 0; m_err = 0;
      m_ready = 1; m_rdata = 32'h0; m_mask = 32'hFFFF_FFFF;
    end else begin
      m_ack = 0;
      if (m_edge >= m_nxt && req) begin
        m_pend = 1; p_we = we; p_addr = addr; p_wdata = wdata; p_be = be;
        m_resp = m_edge + LAT - 1;
        m_nxt  = m_edge + LAT + 1;
      end
      if (m_pend && m_edge == m_resp) begin
        m_pend = 0;
        m_ack  = 1;
        if (p_addr[1:0] != 2'b00 || p_addr[31:2] >= 30'(DEP)) begin
          m_err = 1; m_rdata = 32'h0; m_mask = 32'hFFFF_FFFF;
        end else begin
          m_err = 0;
          m_idx = int'(p_addr[7:2]);
          if (p_we) begin
            for (int i = 0; i < 4; i++) begin
              if (p_be[i]) begin
                mm[m_idx][8*i +: 8] = p_wdata[8*i +: 8];
                bv[m_idx][i] = 1'b1;
              end
            end
          end else begin
            m_rdata = mm[m_idx];
            for (int i = 0; i < 4; i++) m_mask[8*i +: 8] = {8{bv[m_idx][i]}};
          end
        end
      end
      m_ready = (m_edge >= m_nxt - 1);
      m_edge++;
    end
    #1;
    chk("model_ready", ready, m_ready);
    chk("model_ack", ack, m_ack);
    chk("model_err", err, m_ack ? m_err : 1'b0);
    chk("model_rdata", rdata & m_mask, m_rdata & m_mask);
  end

  // Single request on the LATENCY=2 instance; returns the ack-cycle results
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic er,
                     output int lat);
    int g;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    g = 0;
    while (!ready && g < 50) begin @(negedge clk); g++; end
    if (!ready) timeout("accept");
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
    lat = 1;
    while (!ack && lat < 50) begin @(negedge clk); lat++; end
    if (!ack) timeout("ack");
    rd = rdata;
    er = err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [9:0]  acc_m, ack_m;
  logic [7:0]  rdy1_m, ack1_m;
  int          r;

  initial begin
    clrn = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0; be1 = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    clrn = 1'b1;

    // Write then read back one full word
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr_latency", lat, 2);
    chk("wr_err", er, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd_latency", lat, 2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", er, 1'b0);

    // Byte-enable merge
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("be_merge", rd, 32'h11BB33DD);

    // Error responses
    txn(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat);
    txn(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    chk("misalign_err", er, 1'b1);
    chk("misalign_rdata", rd, 32'h0);
    txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("oor_err", er, 1'b1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("oor_no_write", rd, 32'h12345678);
    chk("oor_next_err", er, 1'b0);

    // Request held high for 10 cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    acc_m = '0; ack_m = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      acc_m[k] = ready;
      ack_m[k] = ack;
    end
    req = 1'b0;
    chk("hold_accepts", 32'(acc_m), 32'b10_0100_1001);
    chk("hold_acks", 32'(ack_m), 32'b01_0010_0100);

    // Reset while a write is waiting
    txn(1'b1, 32'h8, 32'h0, 4'hF, rd, er, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h55; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #2 clrn = 1'b0;
    #1;
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_ack", ack, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    txn(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_no_write", rd, 32'h0);

    // LATENCY=1 instance: write, then a held read
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'hCAFEF00D; be1 = 4'hF;
    chk("l1_idle_ready", ready1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("l1_wr_ack", ack1, 1'b1);
    chk("l1_wr_err", err1, 1'b0);
    chk("l1_resp_ready", ready1, 1'b0);
    we1 = 1'b0; wdata1 = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rdy1_m[k] = ready1;
      ack1_m[k] = ack1;
      if (ack1) chk("l1_rd_data", rdata1, 32'hCAFEF00D);
    end
    req1 = 1'b0;
    chk("l1_hold_ready", 32'(rdy1_m), 32'b0101_0101);
    chk("l1_hold_ack", 32'(ack1_m), 32'b1010_1010);

    // Randomized traffic, including ignored requests and occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      clrn  = ($urandom_range(0, 149) != 0);
      req   = ($urandom_range(0, 9) < 6);
      we    = 1'($urandom);
      wdata = $urandom;
      be    = 4'($urandom);
      r     = $urandom_range(0, 7);
      if (r < 6)       addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      else if (r == 6) addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      else             addr = ($urandom | 32'h100) & 32'hFFFF_FFFC;
    end
    @(negedge clk);
    clrn = 1'b1;
    req  = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
